// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the FPU element-product front end.
//   FPU_WIDTH    : IEEE-754 single-precision word width
//   fpu_word_t   : one single-precision word
//   seq_state_t  : sequencer FSM states
//   FP_ONE/FP_ZERO : handy single-precision constants
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int FPU_WIDTH = 32;

    typedef logic [FPU_WIDTH-1:0] fpu_word_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        FINISH   = 2'd3
    } seq_state_t;

    localparam fpu_word_t FP_ONE  = 32'h3F80_0000;
    localparam fpu_word_t FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fpu_seq_buf.sv
// -----------------------------------------------------------------------------
// fpu_seq_buf
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port, asynchronous active-low clear of every entry.
// Ports:
//   clk, rst_n      : clock, async active-low clear
//   we/waddr/wdata  : write port (addresses >= DEPTH are ignored)
//   raddr/rdata     : combinational read (addresses >= DEPTH read as zero)
// -----------------------------------------------------------------------------
module fpu_seq_buf
    import fpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = FPU_WIDTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Address decode by explicit compare, so out-of-range addresses
    // (non power-of-two DEPTH) simply match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == AW'(i)) begin
                    mem_q[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/fpu_pair_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_pair_sequencer
// Element-product front end: holds two VEC_LEN operand vectors, feeds the
// pairs a[i],b[i] one at a time into a non-pipelined FPU multiplier over its
// stb/ack handshakes, stores each product and pulses done at the end.
// Ports:
//   clk, rst                      : clock, async active-low reset
//   load_en/load_idx/load_a/load_b: operand write (IDLE only)
//   start, busy, done             : job control / status
//   rd_idx, rd_data               : combinational product read
//   fpu_input_a/b/stb, fpu_input_ack   : operand handshake to multiplier
//   fpu_output_z/stb, fpu_output_ack   : result handshake from multiplier
//   cycle_cnt (FPU_SEQ_CYCLE_CNT_EN only): busy-cycle count of last job
// Optional feature macro: FPU_SEQ_CYCLE_CNT_EN
// -----------------------------------------------------------------------------
module fpu_pair_sequencer
    import fpu_pkg::*;
#(
    parameter int  VEC_LEN    = 4,
    parameter int  DATA_WIDTH = FPU_WIDTH,
    localparam int IDX_W      = $clog2(VEC_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [DATA_WIDTH-1:0] load_a,
    input  logic [DATA_WIDTH-1:0] load_b,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
`ifdef FPU_SEQ_CYCLE_CNT_EN
    output logic [31:0]           cycle_cnt,
`endif
    output logic [DATA_WIDTH-1:0] fpu_input_a,
    output logic [DATA_WIDTH-1:0] fpu_input_b,
    output logic                  fpu_input_stb,
    input  logic                  fpu_input_ack,
    input  logic [DATA_WIDTH-1:0] fpu_output_z,
    input  logic                  fpu_output_stb,
    output logic                  fpu_output_ack
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    seq_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;

    logic                  load_we;
    logic                  prod_we;
    logic                  fwd_load0;
    logic [IDX_W-1:0]      op_raddr;
    logic [DATA_WIDTH-1:0] opa_rdata, opb_rdata;

    // Operands are writable only while idle, so they stay frozen during a job.
    assign load_we   = load_en && (state_q == IDLE);
    // A load to element 0 in the start cycle must reach the first issue.
    assign fwd_load0 = load_we && (load_idx == '0);

    // The operand read port looks ahead: element 0 while idle, the next
    // element while waiting for a result, so the issue registers can be
    // loaded on the same edge that leaves those states.
    assign op_raddr = (state_q == WAIT_RES) ? idx_q + IDX_W'(1) : '0;

    fpu_seq_buf #(.DEPTH(VEC_LEN), .WIDTH(DATA_WIDTH)) u_opa (
        .clk(clk), .rst_n(rst), .we(load_we), .waddr(load_idx), .wdata(load_a),
        .raddr(op_raddr), .rdata(opa_rdata)
    );

    fpu_seq_buf #(.DEPTH(VEC_LEN), .WIDTH(DATA_WIDTH)) u_opb (
        .clk(clk), .rst_n(rst), .we(load_we), .waddr(load_idx), .wdata(load_b),
        .raddr(op_raddr), .rdata(opb_rdata)
    );

    fpu_seq_buf #(.DEPTH(VEC_LEN), .WIDTH(DATA_WIDTH)) u_prod (
        .clk(clk), .rst_n(rst), .we(prod_we), .waddr(idx_q), .wdata(fpu_output_z),
        .raddr(rd_idx), .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                    a_d     = fwd_load0 ? load_a : opa_rdata;
                    b_d     = fwd_load0 ? load_b : opb_rdata;
                end
            end
            ISSUE: begin
                if (fpu_input_ack) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (fpu_output_stb) begin
                    prod_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        idx_d   = idx_q + IDX_W'(1);
                        a_d     = opa_rdata;
                        b_d     = opb_rdata;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy           = (state_q == ISSUE) || (state_q == WAIT_RES);
    assign done           = (state_q == FINISH);
    assign fpu_input_stb  = (state_q == ISSUE);
    assign fpu_output_ack = (state_q == WAIT_RES);
    assign fpu_input_a    = a_q;
    assign fpu_input_b    = b_q;

`ifdef FPU_SEQ_CYCLE_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start && (state_q == IDLE)) begin
            cnt_q <= '0;
        end else if (busy && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fpu_pair_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_pair_sequencer
// Drives fpu_pair_sequencer with a behavioural multiplier (configurable
// ack / result latency) and compares products against a reference vector
// model computed from the operands the bench loaded.
// -----------------------------------------------------------------------------
module tb_fpu_pair_sequencer;

    localparam int VL = 4;

    logic        clk, rst, load_en, start, busy, done;
    logic [1:0]  load_idx, rd_idx;
    logic [31:0] load_a, load_b, rd_data;
    logic [31:0] fpu_input_a, fpu_input_b, fpu_output_z;
    logic        fpu_input_stb, fpu_input_ack, fpu_output_stb, fpu_output_ack;
`ifdef FPU_SEQ_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int jobs   = 0;

    // multiplier model controls and observations
    int ack_dly = 0;
    int out_dly = 0;
    int xfers = 0, caps = 0, dones = 0, busy_cycles = 0, proto_err = 0;

    logic [31:0] ref_a    [VL];
    logic [31:0] ref_b    [VL];
    logic [31:0] ref_prod [VL];

    fpu_pair_sequencer #(.VEC_LEN(VL), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_idx(load_idx), .load_a(load_a), .load_b(load_b),
        .start(start), .busy(busy), .done(done),
        .rd_idx(rd_idx), .rd_data(rd_data),
`ifdef FPU_SEQ_CYCLE_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .fpu_input_a(fpu_input_a), .fpu_input_b(fpu_input_b),
        .fpu_input_stb(fpu_input_stb), .fpu_input_ack(fpu_input_ack),
        .fpu_output_z(fpu_output_z), .fpu_output_stb(fpu_output_stb),
        .fpu_output_ack(fpu_output_ack)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Multiplier result: exact products for the documented example pairs,
    // an arbitrary but deterministic scramble for everything else.
    function automatic logic [31:0] mul_model(logic [31:0] a, logic [31:0] b);
        if (b == 32'h42B1_CCCD && a == 32'h3F80_0000) return 32'h42B1_CCCD;
        if (b == 32'h42B1_CCCD && a == 32'h4000_0000) return 32'h4331_CCCD;
        if (b == 32'h42B1_CCCD && a == 32'h0000_0000) return 32'h0000_0000;
        if (b == 32'h42B1_CCCD && a == 32'hBF80_0000) return 32'hC2B1_CCCD;
        return (a * 32'h9E37_79B1) ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
    endfunction

    // Behavioural multiplier, acting at every falling edge.
    initial begin
        int m, c, oc;
        logic [31:0] la, lb;
        m = 0; c = 0; oc = 0; la = '0; lb = '0;
        fpu_input_ack = 1'b0; fpu_output_stb = 1'b0; fpu_output_z = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m = 0;
                fpu_input_ack  = 1'b0;
                fpu_output_stb = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (done) dones++;
                if (m == 3) begin
                    // capture happened at the last edge: ack must have fallen
                    if (fpu_output_ack) proto_err++;
                    fpu_output_stb = 1'b0;
                    m = 0;
                end
                if (m == 2) begin
                    fpu_input_ack = 1'b0;
                    if (fpu_input_stb || !fpu_output_ack) proto_err++;
                    if (oc == 0) begin
                        fpu_output_z   = mul_model(la, lb);
                        fpu_output_stb = 1'b1;
                        caps++;
                        m = 3;
                    end else begin
                        oc--;
                    end
                end else if (m == 1) begin
                    if (!fpu_input_stb || fpu_input_a !== la || fpu_input_b !== lb) proto_err++;
                    c--;
                    if (c == 0) begin
                        fpu_input_ack = 1'b1;
                        xfers++;
                        oc = out_dly;
                        m = 2;
                    end
                end else if (m == 0) begin
                    if (fpu_input_stb) begin
                        la = fpu_input_a;
                        lb = fpu_input_b;
                        if (ack_dly == 0) begin
                            fpu_input_ack = 1'b1;
                            xfers++;
                            oc = out_dly;
                            m = 2;
                        end else begin
                            c = ack_dly;
                            m = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input int idx, input logic [31:0] a, input logic [31:0] b, input bit upd);
        load_en  = 1'b1;
        load_idx = idx[1:0];
        load_a   = a;
        load_b   = b;
        tick();
        load_en  = 1'b0;
        if (upd) begin
            ref_a[idx] = a;
            ref_b[idx] = b;
        end
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int d0 = dones;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (dones != d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            for (int i = 0; i < VL; i++) ref_prod[i] = mul_model(ref_a[i], ref_b[i]);
            jobs++;
            $display("job %0d complete at %0t", jobs, $time);
        end
    endtask

    task automatic rd(input int i, output logic [31:0] v);
        rd_idx = i[1:0];
        #1;
        v = rd_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, fpu_input_stb, fpu_output_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {busy, done, fpu_input_stb, fpu_output_ack});
        end
        checks++;
        if (fpu_input_a !== 32'h0 || fpu_input_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_operands got %h/%h want 0/0", fpu_input_a, fpu_input_b);
        end
        for (int i = 0; i < VL; i++) begin
            rd(i, v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_prod[%0d] got %h want 0", i, v);
            end
            ref_a[i] = '0; ref_b[i] = '0; ref_prod[i] = '0;
        end
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ta [VL];
        logic [31:0] exp_p [VL];
        logic [31:0] v;
        bit ok;
        int d0;
        ta[0] = 32'h3F80_0000; ta[1] = 32'h4000_0000; ta[2] = 32'h0000_0000; ta[3] = 32'hBF80_0000;
        exp_p[0] = 32'h42B1_CCCD; exp_p[1] = 32'h4331_CCCD; exp_p[2] = 32'h0000_0000; exp_p[3] = 32'hC2B1_CCCD;
        ack_dly = 0; out_dly = 2;
        for (int i = 0; i < VL; i++) do_load(i, ta[i], 32'h42B1_CCCD, 1'b1);
        d0 = dones;
        start_job();
        checks++;
        if (busy !== 1'b1 || fpu_input_stb !== 1'b1 || fpu_input_a !== ta[0]) begin
            errors++;
            $display("FAIL basic_first_issue busy %b stb %b a %h want 1 1 %h", busy, fpu_input_stb, fpu_input_a, ta[0]);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done_timeout got no done want done");
        end
        tick(); tick(); tick();
        checks++;
        if (dones - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_once dones %0d busy %b want 1 0", dones - d0, busy);
        end
        for (int i = 0; i < VL; i++) begin
            rd(i, v);
            checks++;
            if (v !== exp_p[i]) begin
                errors++;
                $display("FAIL basic_prod[%0d] got %h want %h", i, v, exp_p[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        bit ok;
        for (int j = 0; j < 4; j++) begin
            ack_dly = $urandom_range(0, 3);
            out_dly = $urandom_range(0, 4);
            for (int i = 0; i < VL; i++) begin
                if ($urandom_range(0, 3) != 0) do_load(i, $urandom, $urandom, 1'b1);
            end
            start_job();
            wait_done(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_done_timeout job %0d", j);
            end
            for (int i = 0; i < VL; i++) begin
                rd(i, v);
                checks++;
                if (v !== ref_prod[i]) begin
                    errors++;
                    $display("FAIL random_prod[%0d] job %0d got %h want %h", i, j, v, ref_prod[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] v;
        bit ok;
        int x0, c0, p0;
        ack_dly = 5; out_dly = 20;
        for (int i = 0; i < VL; i++) do_load(i, $urandom, $urandom, 1'b1);
        x0 = xfers; c0 = caps; p0 = proto_err;
        start_job();
        wait_done(ok);
        checks++;
        if (!ok || xfers - x0 != VL || caps - c0 != VL) begin
            errors++;
            $display("FAIL stall_counts xfers %0d caps %0d want %0d %0d", xfers - x0, caps - c0, VL, VL);
        end
        checks++;
        if (proto_err != p0) begin
            errors++;
            $display("FAIL stall_handshake protocol errors %0d want 0", proto_err - p0);
        end
        for (int i = 0; i < VL; i++) begin
            rd(i, v);
            checks++;
            if (v !== ref_prod[i]) begin
                errors++;
                $display("FAIL stall_prod[%0d] got %h want %h", i, v, ref_prod[i]);
            end
        end
        tick();
    endtask

    task automatic test_ignored();
        logic [31:0] v;
        bit ok;
        int d0;
        ack_dly = 2; out_dly = 6;
        for (int i = 0; i < VL; i++) do_load(i, $urandom, $urandom, 1'b1);
        d0 = dones;
        start_job();
        tick(); tick(); tick();
        // mid-job loads and a second start: none of it may take effect
        for (int i = 0; i < VL; i++) begin
            start = 1'b1;
            do_load(i, $urandom, $urandom, 1'b0);
        end
        start = 1'b0;
        wait_done(ok);
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (!ok || dones - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_single_job dones %0d busy %b want 1 0", dones - d0, busy);
        end
        for (int i = 0; i < VL; i++) begin
            rd(i, v);
            checks++;
            if (v !== ref_prod[i]) begin
                errors++;
                $display("FAIL ignored_prod[%0d] got %h want %h", i, v, ref_prod[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bit ok;
        int c0, d0;
        ack_dly = 0; out_dly = 10;
        for (int i = 0; i < VL; i++) do_load(i, $urandom, $urandom, 1'b1);
        c0 = caps;
        start_job();
        for (int k = 0; k < 500 && caps - c0 < 2; k++) tick();
        tick(); tick(); tick();
        checks++;
        if (fpu_output_ack !== 1'b1 || caps - c0 != 2) begin
            errors++;
            $display("FAIL rstmid_reach_elem2 ack %b caps %0d want 1 2", fpu_output_ack, caps - c0);
        end
        d0 = dones;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, fpu_input_stb, fpu_output_ack} !== 4'b0000 ||
            fpu_input_a !== 32'h0 || fpu_input_b !== 32'h0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async ctrl %b a %h b %h rd %h want 0000 0 0 0",
                     {busy, done, fpu_input_stb, fpu_output_ack}, fpu_input_a, fpu_input_b, rd_data);
        end
        for (int i = 0; i < VL; i++) begin
            ref_a[i] = '0; ref_b[i] = '0; ref_prod[i] = '0;
        end
        tick(); tick(); tick();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (dones != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done dones %0d busy %b want 0 0", dones - d0, busy);
        end
        ack_dly = 1; out_dly = 1;
        for (int i = 0; i < VL; i++) do_load(i, $urandom, $urandom, 1'b1);
        start_job();
        wait_done(ok);
        for (int i = 0; i < VL; i++) begin
            rd(i, v);
            checks++;
            if (!ok || v !== ref_prod[i]) begin
                errors++;
                $display("FAIL rstmid_rerun_prod[%0d] got %h want %h", i, v, ref_prod[i]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, na, nb;
        bit ok;
        int c0;
        ack_dly = 1; out_dly = 1;
        for (int i = 0; i < VL; i++) do_load(i, $urandom, $urandom, 1'b1);
        start_job();
        wait_done(ok);
        tick();
        // first idle cycle after done: start together with a fresh element 0
        na = $urandom; nb = $urandom;
        c0 = caps;
        start = 1'b1;
        do_load(0, na, nb, 1'b1);
        start = 1'b0;
        checks++;
        if (!ok || busy !== 1'b1 || fpu_input_a !== na || fpu_input_b !== nb) begin
            errors++;
            $display("FAIL b2b_restart busy %b a %h b %h want 1 %h %h", busy, fpu_input_a, fpu_input_b, na, nb);
        end
        for (int k = 0; k < 500 && caps == c0; k++) tick();
        tick();
        rd(0, v);
        checks++;
        if (v !== mul_model(na, nb)) begin
            errors++;
            $display("FAIL b2b_prod0_early got %h want %h", v, mul_model(na, nb));
        end
        wait_done(ok);
        for (int i = 0; i < VL; i++) begin
            rd(i, v);
            checks++;
            if (!ok || v !== ref_prod[i]) begin
                errors++;
                $display("FAIL b2b_prod[%0d] got %h want %h", i, v, ref_prod[i]);
            end
        end
        tick();
    endtask

`ifdef FPU_SEQ_CYCLE_CNT_EN
    task automatic test_cycle_cnt();
        bit ok;
        int b0, span;
        logic [31:0] held;
        ack_dly = 2; out_dly = 2;
        b0 = busy_cycles;
        start_job();
        wait_done(ok);
        span = busy_cycles - b0;
        checks++;
        if (!ok || cycle_cnt !== 32'(span)) begin
            errors++;
            $display("FAIL cnt_span got %0d want %0d", cycle_cnt, span);
        end
        held = cycle_cnt;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (cycle_cnt !== 32'(span)) begin
            errors++;
            $display("FAIL cnt_hold got %0d want %0d", cycle_cnt, span);
        end
        start_job();
        checks++;
        if (cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt_clear got %0d want 0 (previous %0d)", cycle_cnt, held);
        end
        wait_done(ok);
        tick();
    endtask
`endif

    initial begin
        rst = 1'b0; load_en = 1'b0; start = 1'b0;
        load_idx = '0; load_a = '0; load_b = '0; rd_idx = '0;
        test_reset();
        test_basic();
        test_random();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef FPU_SEQ_CYCLE_CNT_EN
        test_cycle_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_pair_sequencer.md
Name: fpu_pair_sequencer

Overview:
- Sits directly upstream of fpu_multiplier and drives its operand handshake (input_a/input_b/input_stb/input_ack).
- Also consumes the multiplier's result handshake (output_z/output_stb/output_ack).
- Holds two VEC_LEN-entry operand vectors and issues element-wise products a[i]*b[i] one pair at a time.
- Stores the products in a result buffer, then pulses done; it is the element-product front end of the matrix-multiply datapath.

Parameters:
- VEC_LEN, 4, number of operand pairs per job (2..256).
- DATA_WIDTH, 32, IEEE-754 single-precision word width.
- IDX_W, $clog2(VEC_LEN), width of element index (derived localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- load_en  in  1  write operand pair at load_idx.
- load_idx  in  IDX_W  operand write index.
- load_a  in  DATA_WIDTH  operand A word.
- load_b  in  DATA_WIDTH  operand B word.
- start  in  1  begin job (sampled in IDLE only).
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last product is captured.
- rd_idx  in  IDX_W  product read index.
- rd_data  out  DATA_WIDTH  combinational read of prod[rd_idx].
- fpu_input_a  out  DATA_WIDTH  operand A to multiplier.
- fpu_input_b  out  DATA_WIDTH  operand B to multiplier.
- fpu_input_stb  out  1  operand valid.
- fpu_input_ack  in  1  multiplier accepted operands.
- fpu_output_z  in  DATA_WIDTH  product from multiplier.
- fpu_output_stb  in  1  product valid.
- fpu_output_ack  out  1  sequencer ready to take product.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; element index = 0.
  - busy, done, fpu_input_stb and fpu_output_ack = 0.
  - fpu_input_a and fpu_input_b = 0.
  - All operand and product entries = 0.
- FSM states: IDLE, ISSUE, WAIT_RES, FINISH.
- IDLE:
  - load_en writes opa[load_idx] and opb[load_idx] at the clock edge.
  - A load_idx >= VEC_LEN is ignored.
  - start=1 → ISSUE with index=0 and busy=1 at the next edge.
  - start and load_en in the same cycle: the load completes first, so the job uses the new data.
- ISSUE:
  - fpu_input_stb=1 with fpu_input_a=opa[idx] and fpu_input_b=opb[idx], registered and held stable while stb is high.
  - A transfer occurs on the edge where stb and fpu_input_ack are both 1.
  - On transfer: stb falls at that edge, state → WAIT_RES.
  - No operand change while stb is high.
- WAIT_RES:
  - fpu_output_ack=1.
  - On the edge where fpu_output_stb and ack are both 1: prod[idx] ← fpu_output_z and ack falls.
  - If idx==VEC_LEN-1 → FINISH; otherwise idx+1 → ISSUE.
  - At most one operation is outstanding, because the multiplier is not pipelined.
- FINISH:
  - done=1 for exactly one cycle and busy falls at the same edge.
  - State → IDLE.
- Timing: start-to-first-stb latency is 1 cycle. Per-element overhead is 1 cycle beyond the multiplier handshakes.
- Ignored inputs:
  - load_en while busy is ignored; operands are frozen during a job.
  - start while busy or in FINISH is ignored.
- Products are raw multiplier bits; the sequencer performs no rounding or special-value handling.
- rd_data is valid at any time. Products from the previous job persist until overwritten.
- Reset mid-job: the handshake is abandoned immediately, with no done pulse. The multiplier is reset by the same rst, so no stale product arrives.
- Index wrap: idx never exceeds VEC_LEN-1, and the counter is cleared on start.

Optional Feature:
- Macro FPU_SEQ_CYCLE_CNT_EN.
- When defined:
  - Adds output cycle_cnt [31:0], cleared on accepted start.
  - Increments every cycle while busy and saturates at 32'hFFFF_FFFF.
  - Holds its value after done until the next start.
  - Resets to 0.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- fpu_pkg:
  - FPU_WIDTH=32.
  - Typedef fpu_word_t.
  - Enum seq_state_t {IDLE, ISSUE, WAIT_RES, FINISH}.
  - Constants FP_ONE=32'h3F800000 and FP_ZERO=32'h0.
- One sub-module, fpu_seq_buf:
  - Parameterised VEC_LEN x DATA_WIDTH register file.
  - One synchronous write port and one asynchronous read port.
  - Async active-low clear.
  - Instantiated three times: opa, opb, prod.

Test Plan:
- Basic job: load a={1.0,2.0,0,-1.0}={3F800000,40000000,00000000,BF800000}, all b=42B1CCCD, start → prod={42B1CCCD,4331CCCD,00000000,C2B1CCCD}, exactly one done pulse, busy low afterwards.
- Handshake stall: hold fpu_input_ack low for 5 cycles in ISSUE → stb stays high with operands unchanged, then exactly one transfer. Delay fpu_output_stb by 20 cycles → ack stays high and exactly one capture occurs.
- Ignored inputs: load_en and start asserted mid-job → operands and product results unchanged, no second job started.
- Reset mid-job: drop rst during WAIT_RES of element 2 → all outputs 0 asynchronously, no done pulse. A new job after release completes normally.
- Back-to-back: start asserted the cycle after done → new job begins, and rd_data(0) reflects the new product after its capture.
- FPU_SEQ_CYCLE_CNT_EN: with the multiplier modelled at a fixed 6 cycles/op and VEC_LEN=4, cycle_cnt equals the measured start-to-done span. The counter holds after done and clears on the next start.
